// File: rtl/floo_vc_output_scheduler.sv
// Output-port scheduler: round-robin input arbitration, VC selection by most credits,
// packet locking (wormhole) and per-VC credit tracking with a registered ST stage.
module floo_vc_output_scheduler #(
  parameter int NumInputs    = 4,
  parameter int NumVC        = 2,
  parameter int VCDepth      = 2,
  parameter int NumVCWidth   = (NumVC > 1) ? $clog2(NumVC) : 1,
  parameter int VCDepthWidth = $clog2(VCDepth + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumInputs-1:0]              req_v_i,
  input  logic [NumInputs-1:0]              req_last_i,
  input  logic                              credit_v_i,
  input  logic [NumVCWidth-1:0]             credit_id_i,
  output logic                              grant_v_o,
  output logic [NumInputs-1:0]              grant_oh_o,
  output logic [NumVCWidth-1:0]             grant_vc_id_o,
  output logic                              st_v_o,
  output logic [NumInputs-1:0]              st_input_oh_o,
  output logic [NumVCWidth-1:0]             st_vc_id_o,
  output logic [NumVC*VCDepthWidth-1:0]     credit_counter_o,
  output logic                              locked_o,
  output logic                              credit_err_o
);
  localparam int InW = $clog2(NumInputs);

  typedef enum logic {Idle, Locked} state_e;

  state_e                              state_q, state_d;
  logic [InW-1:0]                      rr_ptr_q, rr_ptr_d, lock_in_q, lock_in_d;
  logic [NumVCWidth-1:0]               lock_vc_q, lock_vc_d;
  logic [NumVC-1:0][VCDepthWidth-1:0]  cnt_q, cnt_d;
  logic                                credit_err_q, credit_err_d;
  logic                                st_v_q;
  logic [NumInputs-1:0]                st_oh_q;
  logic [NumVCWidth-1:0]               st_vc_q;

  logic [NumVCWidth-1:0]               cand_vc;
  logic [VCDepthWidth-1:0]             cand_cnt;
  logic [InW-1:0]                      winner;
  logic                                win_found;
  logic                                gnt_v;
  logic [InW-1:0]                      gnt_in;
  logic [NumVCWidth-1:0]               gnt_vc;

  function automatic logic [InW-1:0] next_idx(input logic [InW-1:0] x);
    return (int'(x) == NumInputs - 1) ? '0 : x + 1'b1;
  endfunction

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    cand_vc  = '0;
    cand_cnt = cnt_q[0];
    for (int v = 1; v < NumVC; v++) begin
      if (cnt_q[v] > cand_cnt) begin
        cand_vc  = NumVCWidth'(v);
        cand_cnt = cnt_q[v];
      end
    end
  end

  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    for (int k = 0; k < NumInputs; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NumInputs;
      if (!win_found && req_v_i[idx]) begin
        win_found = 1'b1;
        winner    = InW'(idx);
      end
    end
  end

  always_comb begin
    gnt_v     = 1'b0;
    gnt_in    = winner;
    gnt_vc    = cand_vc;
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_in_d = lock_in_q;
    lock_vc_d = lock_vc_q;
    if (state_q == Idle) begin
      gnt_v = win_found && (cand_cnt != '0) && !rst_i;
      if (gnt_v) begin
        rr_ptr_d = next_idx(winner);
        if (!req_last_i[winner]) begin
          state_d   = Locked;
          lock_in_d = winner;
          lock_vc_d = cand_vc;
        end
      end
    end else begin
      gnt_in = lock_in_q;
      gnt_vc = lock_vc_q;
      gnt_v  = req_v_i[lock_in_q] && (cnt_q[lock_vc_q] != '0) && !rst_i;
      if (gnt_v && req_last_i[lock_in_q]) begin
        state_d  = Idle;
        rr_ptr_d = next_idx(lock_in_q);
      end
    end
  end

  // A credit that meets a grant on the same VC cancels it, so it never overflows.
  always_comb begin
    cnt_d        = cnt_q;
    credit_err_d = credit_v_i && (int'(credit_id_i) >= NumVC);
    for (int v = 0; v < NumVC; v++) begin
      logic inc, dec;
      inc = credit_v_i && (credit_id_i == NumVCWidth'(v));
      dec = gnt_v && (gnt_vc == NumVCWidth'(v));
      if (inc && !dec) begin
        if (cnt_q[v] == VCDepthWidth'(VCDepth)) credit_err_d = 1'b1;
        else                                    cnt_d[v] = cnt_q[v] + 1'b1;
      end else if (dec && !inc) begin
        cnt_d[v] = cnt_q[v] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= Idle;
      rr_ptr_q     <= '0;
      lock_in_q    <= '0;
      lock_vc_q    <= '0;
      cnt_q        <= {NumVC{VCDepthWidth'(VCDepth)}};
      credit_err_q <= 1'b0;
      st_v_q       <= 1'b0;
      st_oh_q      <= '0;
      st_vc_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_in_q    <= lock_in_d;
      lock_vc_q    <= lock_vc_d;
      cnt_q        <= cnt_d;
      credit_err_q <= credit_err_d;
      st_v_q       <= gnt_v;
      st_oh_q      <= grant_oh_o;
      st_vc_q      <= grant_vc_id_o;
    end
  end

  assign grant_v_o        = gnt_v;
  assign grant_oh_o       = gnt_v ? (NumInputs'(1) << gnt_in) : '0;
  assign grant_vc_id_o    = gnt_vc;
  assign st_v_o           = st_v_q;
  assign st_input_oh_o    = st_oh_q;
  assign st_vc_id_o       = st_vc_q;
  assign credit_counter_o = cnt_q;
  assign locked_o         = (state_q == Locked);
  assign credit_err_o     = credit_err_q;
endmodule

// File: doc/floo_vc_output_scheduler.md
FLOO_VC_OUTPUT_SCHEDULER -- requirements
Module: floo_vc_output_scheduler

Interface
REQ-001 SHALL have parameter NumInputs, default 4: number of requesting input ports (at least 2).
REQ-002 SHALL have parameter NumVC, default 2: number of virtual channels at the downstream input port (at least 1).
REQ-003 SHALL have parameter VCDepth, default 2: downstream buffer depth per VC, in flits.
REQ-004 SHALL have derived parameter NumVCWidth = max(1, $clog2(NumVC)), and derived parameter VCDepthWidth = $clog2(VCDepth+1).
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  reset, asynchronous and active-high.
REQ-007 req_v_i  in  NumInputs  per-input request: a head flit is pending for this output.
REQ-008 req_last_i  in  NumInputs  the pending flit is the tail of its packet.
REQ-009 credit_v_i  in  1  credit returned by the downstream router.
REQ-010 credit_id_i  in  NumVCWidth  VC that the returned credit belongs to.
REQ-011 grant_v_o  out  1  combinational grant, issued this cycle.
REQ-012 grant_oh_o  out  NumInputs  one-hot winning input; all-zero when grant_v_o=0.
REQ-013 grant_vc_id_o  out  NumVCWidth  output VC assigned to the granted flit.
REQ-014 st_v_o  out  1  switch-traversal strobe: grant_v_o registered by one cycle.
REQ-015 st_input_oh_o  out  NumInputs  grant_oh_o registered by one cycle.
REQ-016 st_vc_id_o  out  NumVCWidth  grant_vc_id_o registered by one cycle.
REQ-017 credit_counter_o  out  NumVC*VCDepthWidth  current credit count of each VC.
REQ-018 locked_o  out  1  high while a packet holds the output.
REQ-019 credit_err_o  out  1  one-cycle pulse when an incoming credit is dropped.

Function
REQ-020 Credit counters: one per VC.
- A grant on VC v decrements counter v.
- credit_v_i increments counter credit_id_i.
- Both on the same VC in the same cycle: the counter is unchanged.
REQ-021 Credit increments that would exceed VCDepth, or that carry credit_id_i >= NumVC, SHALL be dropped and SHALL pulse credit_err_o in the following cycle.
REQ-022 A grant SHALL never be issued on a VC whose counter is 0, so counters never underflow.
REQ-023 A credit arriving in cycle t SHALL be usable for a grant in cycle t+1, not in cycle t.
REQ-024 State machine: IDLE and LOCKED; reset state is IDLE.
REQ-025 In IDLE:
- Candidate VC = the VC with the largest credit count; ties go to the lowest index.
- A grant is issued if any req_v_i is set and the candidate VC has credit.
REQ-026 IDLE input arbitration SHALL be round-robin: search starts at rr_ptr and increases with wrap-around.
- After a grant to input i, rr_ptr becomes (i+1) mod NumInputs.
- rr_ptr SHALL NOT move in cycles without a grant.
REQ-027 An IDLE grant with req_last_i[winner]=0 SHALL move the FSM to LOCKED and record lock_input=winner, lock_vc=the granted VC.
- An IDLE grant with req_last_i[winner]=1 (single-flit packet) stays in IDLE.
REQ-028 In LOCKED:
- Only lock_input is considered, on lock_vc only.
- A grant is issued when req_v_i[lock_input]=1 and counter[lock_vc]>0.
- Requests from all other inputs are ignored.
REQ-029 A LOCKED grant with req_last_i[lock_input]=1 SHALL return the FSM to IDLE; rr_ptr becomes (lock_input+1) mod NumInputs.
REQ-030 locked_o SHALL be 1 exactly while the FSM is in LOCKED.
REQ-031 st_v_o, st_input_oh_o and st_vc_id_o SHALL be exactly the grant outputs of the previous cycle; this is a latency of 1 cycle.
REQ-032 The block SHALL sustain one grant per cycle when requests and credits allow.

Reset
REQ-033 While rst_i is high:
- credit counters = VCDepth; FSM = IDLE; rr_ptr = 0;
- st_v_o = 0, st_input_oh_o = 0, st_vc_id_o = 0;
- credit_err_o = 0, locked_o = 0.
REQ-034 Reset asserted mid-packet SHALL abandon the lock immediately (asynchronously), with no grant in the reset cycles.
REQ-035 grant_v_o SHALL be 0 while rst_i is high.

Verification
REQ-036 After reset, with NumVC=2 and VCDepth=2, drive req_v_i=4'b0101, last=1 for four cycles -> grants go to inputs 0,2,0,2 on VCs 0,1,0,1; both counters end at 0; st_v_o follows one cycle later.
REQ-037 Input 1 sends a 3-flit packet while input 3 requests constantly -> locked_o=1 for two cycles; all three flits go to input 1 on the same VC; input 3 is granted next.
REQ-038 Locked on VC0 with counter 0 and VC1 at 2 -> no grant; credit_v_i=1, credit_id_i=0 in cycle t -> grant in cycle t+1 on VC0.
REQ-039 Counter 1 at VCDepth, credit_v_i=1, credit_id_i=1 -> counter unchanged; credit_err_o=1 for one cycle.
REQ-040 Grant and credit on the same VC in the same cycle -> counter unchanged.
REQ-041 Assert rst_i while LOCKED -> locked_o=0 and all counters=VCDepth immediately; the first grant after reset goes to input 0 if it requests.
